multicycle_control: RTL and testbench

- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives every datapath select and enable: ALU operand muxes (ALUSrcA, ALUSrcB), memory, IR, register file and PC.
- Consumes the IR opcode and the ALU zero flag.

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/control_output_decode.sv | 63 ++++++
 rtl/multicycle_control.sv | 87 ++++++++
 tb/tb_multicycle_control.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes, state
// codes, datapath select encodings and the decoded control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'd0,
    SRCB_FOUR  = 2'd1,
    SRCB_SEXT  = 2'd2,
    SRCB_SHIFT = 2'd3
  } srcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_t;

  typedef struct packed {
    logic   iord;
    logic   mem_write;
    logic   ir_write;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   reg_write;
    logic   alu_src_a;
    srcb_t  alu_src_b;
    aluop_t alu_op;
    pcsrc_t pc_src;
    logic   pc_write;
    logic   branch;
    logic   instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/control_output_decode.sv
// Pure combinational Moore decode: registered state code -> datapath control word.
module control_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_SHIFT;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;  // codes 12-15 drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, opcode-driven
// next-state logic, reset gating of every output and the PC load enable.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [STW-1:0] state
);

  logic [STW-1:0] state_q;
  logic [STW-1:0] state_d;
  ctrl_t          ctrl;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if      (opcode == OP_LW) state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;  // last states and illegal codes return to fetch
    endcase
  end

  control_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Reset masks every output so an abandoned instruction cannot write anything.
  assign IorD       = ~rst & ctrl.iord;
  assign MemWrite   = ~rst & ctrl.mem_write;
  assign IRWrite    = ~rst & ctrl.ir_write;
  assign RegDst     = ~rst & ctrl.reg_dst;
  assign MemtoReg   = ~rst & ctrl.mem_to_reg;
  assign RegWrite   = ~rst & ctrl.reg_write;
  assign ALUSrcA    = ~rst & ctrl.alu_src_a;
  assign ALUSrcB    = rst ? 2'b00 : ctrl.alu_src_b;
  assign ALUOp      = rst ? 2'b00 : ctrl.alu_op;
  assign PCSrc      = rst ? 2'b00 : ctrl.pc_src;
  assign PCEn       = ~rst & (ctrl.pc_write | (ctrl.branch & zero));
  assign instr_done = ~rst & ctrl.instr_done;
  assign illegal_op = ~rst & (state_q == S_DECODE) & ~is_legal_op(opcode);
  assign state      = rst ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a spec-level reference model pushes
// the expected output vector each cycle and the sampled DUT outputs are popped against it.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, instr_done, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_st   = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %05h expected %05h (state,IorD..ALUSrcA,SrcB,Op,PCSrc,PCEn,done,ill)",
               tag, got, exp);
    else
      n_pass++;
  endtask

  // Output vector: {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
  //                 ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, instr_done, illegal_op}
  function automatic logic [19:0] model_out(input int st, input logic [5:0] op, input logic z);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    logic pcw = 0, br = 0, done = 0, ill = 0;
    case (st)
      0:  begin irw = 1; sb = 2'd1; pcw = 1; end
      1:  begin
            sb  = 2'd3;
            ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
          end
      2:  begin sa = 1; sb = 2'd2; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iord = 1; mw = 1; done = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; done = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'd1; br = 1; done = 1; end
      9:  begin sa = 1; sb = 2'd2; end
      10: begin rw = 1; done = 1; end
      11: begin ps = 2'd2; pcw = 1; done = 1; end
      default: ;
    endcase
    return {4'(st), iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pcw | (br & z), done, ill};
  endfunction

  function automatic int model_next(input int st, input logic [5:0] op);
    case (st)
      0: return 1;
      1: case (op)
           6'b100011, 6'b101011: return 2;
           6'b000000:            return 6;
           6'b000100:            return 8;
           6'b001000:            return 9;
           6'b000010:            return 11;
           default:              return 0;
         endcase
      2: return (op == 6'b100011) ? 3 : (op == 6'b101011) ? 5 : 0;
      3: return 4;
      6: return 7;
      9: return 10;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle at the falling edge, push the expectation, sample 1 ns later.
  task automatic cycle(input logic r, input logic [5:0] op, input logic z, input string tag);
    logic [19:0] got;
    @(negedge clk);
    rst = r; opcode = op; zero = z;
    sb_q.push_back(r ? 20'h0 : model_out(exp_st, op, z));
    #1;
    got = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, PCSrc, PCEn, instr_done, illegal_op};
    if (sb_q.size() == 0) check({tag, "_empty"}, got, ~got);
    else                  check(tag, got, sb_q.pop_front());
    exp_st = r ? 0 : model_next(exp_st, op);
  endtask

  // Real opcode only where it is sampled; noise elsewhere must be ignored.
  task automatic run_instr(input logic [5:0] op, input logic zv, input int n, input string tag);
    logic [5:0] drv_op;
    logic       drv_z;
    for (int i = 0; i < n; i++) begin
      drv_op = (exp_st == 1 || exp_st == 2) ? op : 6'($urandom);
      drv_z  = (exp_st == 8) ? zv : 1'($urandom);
      cycle(1'b0, drv_op, drv_z, $sformatf("%s_c%0d", tag, i));
    end
  endtask

  initial begin
    cycle(1'b1, 6'($urandom), 1'($urandom), "reset0");
    cycle(1'b1, 6'($urandom), 1'($urandom), "reset1");
    run_instr(6'b100011, 1'b0, 5, "lw");
    run_instr(6'b000100, 1'b1, 3, "beq_taken");
    run_instr(6'b000100, 1'b0, 3, "beq_not");
    run_instr(6'b000000, 1'b0, 4, "rtype");
    run_instr(6'b001000, 1'b0, 4, "addi");
    run_instr(6'b101011, 1'b0, 4, "sw");
    run_instr(6'b000010, 1'b0, 3, "jump");
    run_instr(6'b111111, 1'b0, 2, "illegal");
    run_instr(6'b101011, 1'b0, 3, "sw_abort");
    cycle(1'b1, 6'b101011, 1'b0, "rst_in_memwr");
    run_instr(6'b100011, 1'b0, 5, "lw_after_rst");
    run_instr(6'b000000, 1'b0, 1, "final_fetch");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
